// File: rtl/thunderbird_seq.sv
// Sequential tail-light controller: LAMPS lamps per side, turn sequencing,
// hazard flashing and a brake overlay, stepped by an internal tick divider.
module thunderbird_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = $clog2(TICK_DIV) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             step,
    output logic [1:0]       mode
);

    localparam int PW = $clog2(LAMPS + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PH_MAX  = PW'(LAMPS);
    localparam logic [LAMPS-1:0] ONES    = {LAMPS{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     phase, phase_nx;
    logic              haz_on, haz_on_nx;
    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic              haz_req;
    logic [LAMPS-1:0]  img, img_l, img_r;

    assign tick    = (cnt == CNT_TOP);
    assign haz_req = hazard | (left & right);
    assign step    = tick;
    assign mode    = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            phase  <= '0;
            haz_on <= 1'b0;
            lamp_l <= '0;
            lamp_r <= '0;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            haz_on <= haz_on_nx;
            lamp_l <= img_l;
            lamp_r <= img_r;
        end
    end

    // Sequence/hazard state only moves on a tick; priority haz_req > left > right.
    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        haz_on_nx = haz_on;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (haz_req) begin
                        state_nx  = HAZARD;
                        haz_on_nx = 1'b1;
                    end else if (left) begin
                        state_nx = LEFT;
                        phase_nx = PW'(1);
                    end else if (right) begin
                        state_nx = RIGHT;
                        phase_nx = PW'(1);
                    end
                end
                LEFT, RIGHT: begin
                    if (haz_req) begin
                        state_nx  = HAZARD;
                        phase_nx  = '0;
                        haz_on_nx = 1'b1;
                    end else if (phase < PH_MAX) begin
                        phase_nx = phase + PW'(1);
                    end else begin
                        state_nx = IDLE;
                        phase_nx = '0;
                    end
                end
                HAZARD: begin
                    // Always complete the off half before leaving.
                    if (haz_on) begin
                        haz_on_nx = 1'b0;
                    end else if (haz_req) begin
                        haz_on_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        img = '0;
        for (int i = 0; i < LAMPS; i++) begin
            img[i] = (i < int'(phase_nx));
        end
    end

    // Brake overlay is evaluated every cycle against the upcoming state.
    always_comb begin
        img_l = '0;
        img_r = '0;
        case (state_nx)
            IDLE: begin
                img_l = brake ? ONES : '0;
                img_r = brake ? ONES : '0;
            end
            LEFT: begin
                img_l = img;
                img_r = brake ? ONES : '0;
            end
            RIGHT: begin
                img_l = brake ? ONES : '0;
                img_r = img;
            end
            HAZARD: begin
                img_l = haz_on_nx ? ONES : '0;
                img_r = haz_on_nx ? ONES : '0;
            end
            default: begin
                img_l = '0;
                img_r = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_thunderbird_seq.sv
// Scoreboard bench: three configurations share stimulus; a cycle-level
// reference model predicts lamps/mode/step, a monitor compares after each edge.
module tb_thunderbird_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;

    logic [2:0] l3, r3;
    logic [0:0] l1, r1;
    logic [4:0] l5, r5;
    logic       s3, s1, s5;
    logic [1:0] m3, m1, m5;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    thunderbird_seq #(.LAMPS(3), .TICK_DIV(4)) u_d3 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .lamp_l(l3), .lamp_r(r3), .step(s3), .mode(m3));
    thunderbird_seq #(.LAMPS(1), .TICK_DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .lamp_l(l1), .lamp_r(r1), .step(s1), .mode(m1));
    thunderbird_seq #(.LAMPS(5), .TICK_DIV(1)) u_d5 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .lamp_l(l5), .lamp_r(r5), .step(s5), .mode(m5));

    // md: 0 idle, 1 left, 2 right, 3 hazard; since = edges since reset
    typedef struct {
        int md; int ph; int on; int since;
        int el; int er; int stp;
    } model_t;

    model_t st3, st1, st5;
    model_t q3[$], q1[$], q5[$];

    function automatic model_t mstep(model_t s, int L, int TD,
                                     bit rs, bit l, bit r, bit h, bit b);
        model_t n = s;
        int all = (1 << L) - 1;
        bit haz = h | (l & r);
        if (!rs) begin
            n.md = 0; n.ph = 0; n.on = 0; n.since = 0;
            n.el = 0; n.er = 0;
            n.stp = (TD == 1);
            return n;
        end
        if (s.since % TD == TD - 1) begin
            if (s.md == 0) begin
                if (haz) begin n.md = 3; n.on = 1; end
                else if (l) begin n.md = 1; n.ph = 1; end
                else if (r) begin n.md = 2; n.ph = 1; end
            end else if (s.md == 3) begin
                if (s.on == 1) n.on = 0;
                else if (haz) n.on = 1;
                else n.md = 0;
            end else begin
                if (haz) begin n.md = 3; n.on = 1; n.ph = 0; end
                else if (s.ph < L) n.ph = s.ph + 1;
                else begin n.md = 0; n.ph = 0; end
            end
        end
        n.since = s.since + 1;
        n.stp = (n.since % TD == TD - 1);
        case (n.md)
            0: begin n.el = b ? all : 0; n.er = b ? all : 0; end
            1: begin n.el = (1 << n.ph) - 1; n.er = b ? all : 0; end
            2: begin n.el = b ? all : 0; n.er = (1 << n.ph) - 1; end
            default: begin n.el = n.on ? all : 0; n.er = n.on ? all : 0; end
        endcase
        return n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic drive(bit rs, bit l, bit r, bit h, bit b, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = rs; left = l; right = r; hazard = h; brake = b;
            st3 = mstep(st3, 3, 4, rs, l, r, h, b); q3.push_back(st3);
            st1 = mstep(st1, 1, 1, rs, l, r, h, b); q1.push_back(st1);
            st5 = mstep(st5, 5, 1, rs, l, r, h, b); q5.push_back(st5);
        end
    endtask

    // Monitor: outputs are valid every cycle once stimulus has been queued.
    initial begin
        model_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("d3.lamp_l", int'(l3), e.el);
                chk("d3.lamp_r", int'(r3), e.er);
                chk("d3.mode",   int'(m3), e.md);
                chk("d3.step",   int'(s3), e.stp);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1.lamp_l", int'(l1), e.el);
                chk("d1.lamp_r", int'(r1), e.er);
                chk("d1.mode",   int'(m1), e.md);
                chk("d1.step",   int'(s1), e.stp);
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                chk("d5.lamp_l", int'(l5), e.el);
                chk("d5.lamp_r", int'(r5), e.er);
                chk("d5.mode",   int'(m5), e.md);
                chk("d5.step",   int'(s5), e.stp);
            end
        end
    end

    initial begin
        st3 = '{default: 0};
        st1 = '{default: 0};
        st5 = '{default: 0};
        // reset, left held, left pulse, left then both, release
        drive(0, 0, 0, 0, 0, 2);
        drive(1, 1, 0, 0, 0, 20);
        drive(1, 0, 0, 0, 0, 6);
        drive(1, 1, 0, 0, 0, 4);
        drive(1, 0, 0, 0, 0, 20);
        drive(1, 1, 0, 0, 0, 9);
        drive(1, 1, 1, 0, 0, 14);
        drive(1, 0, 0, 0, 0, 14);
        // brake in idle, in right, in hazard
        drive(1, 0, 0, 0, 1, 6);
        drive(1, 0, 1, 0, 1, 16);
        drive(1, 0, 0, 1, 1, 12);
        drive(1, 0, 0, 0, 0, 12);
        // reset mid-sequence
        drive(1, 0, 1, 0, 0, 10);
        drive(0, 0, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 10);
        // random segments
        for (int k = 0; k < 600; k++) begin
            bit rs = ($urandom_range(0, 49) != 0);
            bit l  = ($urandom_range(0, 9) < 3);
            bit r  = ($urandom_range(0, 9) < 3);
            bit h  = ($urandom_range(0, 9) == 0);
            bit b  = ($urandom_range(0, 9) < 2);
            drive(rs, l, r, h, b, rs ? int'($urandom_range(1, 12)) : 1);
        end
        drive(1, 0, 0, 0, 0, 3);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q3.size() + q1.size() + q5.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
